// File: rtl/sap_1_controller_sequencer.sv
// ---------------------------------------------------------------------------
// sap_1_controller_sequencer
//
// Purpose:
//   Controller-sequencer for the SAP-1 datapath. A one-hot six-state ring
//   (T1..T6) advances on every falling edge of Clk. The control word is a
//   combinational decode of the ring state, plus the opcode during T4..T6.
//   Registers in the datapath sample the control word on the rising edge in
//   the middle of each T-state. HLT sets a halt latch that freezes the ring
//   at T4. Only ClrN clears the halt latch.
//
// Ports:
//   Clk     in   1  system clock; state changes on the falling edge
//   ClrN    in   1  asynchronous active-low reset
//   Opcode  in   4  IR upper nibble; must be stable from T4 through T6
//   Cp      out  1  PC count enable
//   Ep      out  1  PC drives W bus
//   LmN     out  1  MAR load (active-low)
//   CEN     out  1  RAM drives W bus (active-low)
//   LiN     out  1  IR load (active-low)
//   EiN     out  1  IR operand drives W bus (active-low)
//   LaN     out  1  accumulator load (active-low)
//   Ea      out  1  accumulator drives W bus
//   Su      out  1  ALU subtract select
//   Eu      out  1  ALU drives W bus
//   LbN     out  1  B register load (active-low)
//   LoN     out  1  output register load (active-low)
//   Halt    out  1  machine halted
//   TState  out  6  one-hot ring state, bit0=T1 .. bit5=T6
//
// Build option:
//   SAP_1_CONTROLLER_SHORT_CYCLE_EN - when defined, an instruction returns
//   the ring to T1 after its last active state: LDA after T5, OUT and
//   unknown opcodes after T4. ADD and SUB still use all six states.
//   When undefined, every instruction takes six states.
//
// States:
//   state | meaning
//   T1    | address: PC -> MAR
//   T2    | increment: PC += 1
//   T3    | memory: RAM -> IR
//   T4    | execute 1 (HLT is decoded here and freezes the ring)
//   T5    | execute 2
//   T6    | execute 3
// ---------------------------------------------------------------------------
module sap_1_controller_sequencer (
  input  logic       Clk,
  input  logic       ClrN,
  input  logic [3:0] Opcode,
  output logic       Cp,
  output logic       Ep,
  output logic       LmN,
  output logic       CEN,
  output logic       LiN,
  output logic       EiN,
  output logic       LaN,
  output logic       Ea,
  output logic       Su,
  output logic       Eu,
  output logic       LbN,
  output logic       LoN,
  output logic       Halt,
  output logic [5:0] TState
);

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } state_t;

  state_t r_state;
  state_t w_next_state;
  logic   r_halt;
  logic   w_next_halt;

  logic   w_is_lda;
  logic   w_is_add_sub;

  assign w_is_lda     = (Opcode == OP_LDA);
  assign w_is_add_sub = (Opcode == OP_ADD) || (Opcode == OP_SUB);

  assign TState = r_state;
  assign Halt   = r_halt;

  always_ff @(negedge Clk or negedge ClrN) begin
    if (!ClrN) begin
      r_state <= T1;
      r_halt  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_halt  <= w_next_halt;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_halt  = r_halt;
    if (!r_halt) begin
      case (r_state)
        T1: w_next_state = T2;
        T2: w_next_state = T3;
        T3: w_next_state = T4;
        T4: begin
          if (Opcode == OP_HLT) begin
            // Ring parks on T4 until reset.
            w_next_halt  = 1'b1;
            w_next_state = T4;
          end else begin
`ifdef SAP_1_CONTROLLER_SHORT_CYCLE_EN
            if (w_is_lda || w_is_add_sub) w_next_state = T5;
            else                          w_next_state = T1;
`else
            w_next_state = T5;
`endif
          end
        end
        T5: begin
`ifdef SAP_1_CONTROLLER_SHORT_CYCLE_EN
          if (w_is_lda) w_next_state = T1;
          else          w_next_state = T6;
`else
          w_next_state = T6;
`endif
        end
        T6:      w_next_state = T1;
        default: w_next_state = T1;
      endcase
    end
  end

  // Control word decode. Gating with ClrN keeps every strobe inactive for
  // the whole reset pulse, even though the ring itself already reads T1.
  always_comb begin
    Cp  = 1'b0;
    Ep  = 1'b0;
    LmN = 1'b1;
    CEN = 1'b1;
    LiN = 1'b1;
    EiN = 1'b1;
    LaN = 1'b1;
    Ea  = 1'b0;
    Su  = 1'b0;
    Eu  = 1'b0;
    LbN = 1'b1;
    LoN = 1'b1;
    if (ClrN && !r_halt) begin
      case (r_state)
        T1: begin
          Ep  = 1'b1;
          LmN = 1'b0;
        end
        T2: Cp = 1'b1;
        T3: begin
          CEN = 1'b0;
          LiN = 1'b0;
        end
        T4: begin
          if (w_is_lda || w_is_add_sub) begin
            EiN = 1'b0;
            LmN = 1'b0;
          end else if (Opcode == OP_OUT) begin
            Ea  = 1'b1;
            LoN = 1'b0;
          end
        end
        T5: begin
          if (w_is_lda) begin
            CEN = 1'b0;
            LaN = 1'b0;
          end else if (w_is_add_sub) begin
            CEN = 1'b0;
            LbN = 1'b0;
          end
        end
        T6: begin
          if (w_is_add_sub) begin
            Eu  = 1'b1;
            Su  = (Opcode == OP_SUB);
            LaN = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sap_1_controller_sequencer.sv
module tb_sap_1_controller_sequencer;

  logic       Clk;
  logic       ClrN;
  logic [3:0] Opcode;
  logic       Cp, Ep, LmN, CEN, LiN, EiN, LaN, Ea, Su, Eu, LbN, LoN, Halt;
  logic [5:0] TState;

  int checks   = 0;
  int failures = 0;

  // Control word packing: {Cp,Ep,LmN,CEN,LiN,EiN,LaN,Ea,Su,Eu,LbN,LoN}
  logic [11:0] ctrl;
  assign ctrl = {Cp, Ep, LmN, CEN, LiN, EiN, LaN, Ea, Su, Eu, LbN, LoN};

  localparam logic [11:0] C_IDLE   = 12'b0011_1110_0011;
  localparam logic [11:0] C_T1     = 12'b0101_1110_0011;
  localparam logic [11:0] C_T2     = 12'b1011_1110_0011;
  localparam logic [11:0] C_T3     = 12'b0010_0110_0011;
  localparam logic [11:0] C_T4_MEM = 12'b0001_1010_0011;
  localparam logic [11:0] C_T5_LDA = 12'b0010_1100_0011;
  localparam logic [11:0] C_T5_ADD = 12'b0010_1110_0001;
  localparam logic [11:0] C_T6_ADD = 12'b0011_1100_0111;
  localparam logic [11:0] C_T6_SUB = 12'b0011_1100_1111;
  localparam logic [11:0] C_T4_OUT = 12'b0011_1111_0010;

  localparam logic [5:0] S1 = 6'b000001;
  localparam logic [5:0] S2 = 6'b000010;
  localparam logic [5:0] S3 = 6'b000100;
  localparam logic [5:0] S4 = 6'b001000;
  localparam logic [5:0] S5 = 6'b010000;
  localparam logic [5:0] S6 = 6'b100000;

`ifdef SAP_1_CONTROLLER_SHORT_CYCLE_EN
  localparam int LEN_LDA = 5;
  localparam int LEN_OUT = 4;
`else
  localparam int LEN_LDA = 6;
  localparam int LEN_OUT = 6;
`endif
  localparam int LEN_ADD = 6;

  sap_1_controller_sequencer dut (
    .Clk(Clk), .ClrN(ClrN), .Opcode(Opcode),
    .Cp(Cp), .Ep(Ep), .LmN(LmN), .CEN(CEN), .LiN(LiN), .EiN(EiN),
    .LaN(LaN), .Ea(Ea), .Su(Su), .Eu(Eu), .LbN(LbN), .LoN(LoN),
    .Halt(Halt), .TState(TState)
  );

  initial Clk = 1'b1;
  always #5 Clk = ~Clk;

  // Advance one T-state and sample 2 time units after the falling edge.
  task automatic fall();
    @(negedge Clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [5:0] exp_t,
                       input logic [11:0] exp_c, input logic exp_h);
    checks++;
    assert (TState === exp_t) else begin
      failures++;
      $error("FAIL %s tstate observed=%b expected=%b", tag, TState, exp_t);
    end
    checks++;
    assert (ctrl === exp_c) else begin
      failures++;
      $error("FAIL %s ctrl observed=%b expected=%b", tag, ctrl, exp_c);
    end
    checks++;
    assert (Halt === exp_h) else begin
      failures++;
      $error("FAIL %s halt observed=%b expected=%b", tag, Halt, exp_h);
    end
  endtask

  // Release reset 1 unit after a falling edge so T1 lasts almost a full cycle.
  task automatic release_reset();
    @(negedge Clk);
    #1 ClrN = 1'b1;
    #1;
  endtask

  // From T1, count falling edges until the ring is back at T1.
  task automatic run_count(input string tag, input logic [3:0] op, input int exp_n);
    int n;
    Opcode = op;
    n = 0;
    do begin
      fall();
      n++;
    end while (TState !== S1 && n < 12);
    checks++;
    assert (n == exp_n) else begin
      failures++;
      $error("FAIL %s cycles observed=%0d expected=%0d", tag, n, exp_n);
    end
  endtask

  int cp_cnt;

  initial begin
    ClrN   = 1'b0;
    Opcode = 4'b0000;
    #7;
    check("reset", S1, C_IDLE, 1'b0);
    release_reset();

    // LDA free-run
    check("lda_t1", S1, C_T1, 1'b0);
    fall(); check("lda_t2", S2, C_T2, 1'b0);
    fall(); check("lda_t3", S3, C_T3, 1'b0);
    fall(); check("lda_t4", S4, C_T4_MEM, 1'b0);
    fall(); check("lda_t5", S5, C_T5_LDA, 1'b0);
`ifndef SAP_1_CONTROLLER_SHORT_CYCLE_EN
    fall(); check("lda_t6", S6, C_IDLE, 1'b0);
`endif
    fall(); check("lda_wrap", S1, C_T1, 1'b0);

    // ADD
    Opcode = 4'b0001;
    fall(); check("add_t2", S2, C_T2, 1'b0);
    fall(); check("add_t3", S3, C_T3, 1'b0);
    fall(); check("add_t4", S4, C_T4_MEM, 1'b0);
    fall(); check("add_t5", S5, C_T5_ADD, 1'b0);
    fall(); check("add_t6", S6, C_T6_ADD, 1'b0);
    fall(); check("add_wrap", S1, C_T1, 1'b0);

    // SUB
    Opcode = 4'b0010;
    fall(); check("sub_t2", S2, C_T2, 1'b0);
    fall(); check("sub_t3", S3, C_T3, 1'b0);
    fall(); check("sub_t4", S4, C_T4_MEM, 1'b0);
    fall(); check("sub_t5", S5, C_T5_ADD, 1'b0);
    fall(); check("sub_t6", S6, C_T6_SUB, 1'b0);
    fall(); check("sub_wrap", S1, C_T1, 1'b0);

    // OUT
    Opcode = 4'b1110;
    fall(); fall();
    fall(); check("out_t4", S4, C_T4_OUT, 1'b0);
`ifndef SAP_1_CONTROLLER_SHORT_CYCLE_EN
    fall(); check("out_t5", S5, C_IDLE, 1'b0);
    fall(); check("out_t6", S6, C_IDLE, 1'b0);
`endif
    fall(); check("out_wrap", S1, C_T1, 1'b0);

    // Unknown opcode behaves as NOP
    Opcode = 4'b0101;
    fall(); fall();
    fall(); check("nop_t4", S4, C_IDLE, 1'b0);
`ifndef SAP_1_CONTROLLER_SHORT_CYCLE_EN
    fall(); check("nop_t5", S5, C_IDLE, 1'b0);
    fall(); check("nop_t6", S6, C_IDLE, 1'b0);
`endif
    fall(); check("nop_wrap", S1, C_T1, 1'b0);

    // HLT
    Opcode = 4'b1111;
    fall(); fall();
    fall(); check("hlt_t4", S4, C_IDLE, 1'b0);
    fall(); check("hlt_set", S4, C_IDLE, 1'b1);
    for (int i = 0; i < 10; i++) begin
      fall();
      check("hlt_hold", S4, C_IDLE, 1'b1);
    end
    ClrN = 1'b0;
    #1 check("hlt_clr", S1, C_IDLE, 1'b0);
    release_reset();
    check("hlt_exit", S1, C_T1, 1'b0);

    // Async reset in the middle of T5
    Opcode = 4'b0001;
    fall(); fall(); fall(); fall();
    check("ar_t5", S5, C_T5_ADD, 1'b0);
    ClrN = 1'b0;
    #1 check("ar_async", S1, C_IDLE, 1'b0);
    release_reset();
    check("ar_t1", S1, C_T1, 1'b0);
    cp_cnt = 0;
    for (int i = 0; i < 18; i++) begin
      if (Cp === 1'b1) cp_cnt++;
      fall();
    end
    checks++;
    assert (cp_cnt == 3) else begin
      failures++;
      $error("FAIL ar_cp_count observed=%0d expected=%0d", cp_cnt, 3);
    end
    check("ar_end", S1, C_T1, 1'b0);

    // Instruction lengths
    run_count("len_lda", 4'b0000, LEN_LDA);
    run_count("len_add", 4'b0001, LEN_ADD);
    run_count("len_out", 4'b1110, LEN_OUT);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    failures++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
